i3c_tgt_sdr_enthdr_rx: RTL and testbench
========================================

// Module: i3c_tgt_sdr_enthdr_rx
// PURPOSE
// - Target-side SDR front end, the bus peer of the controller's SDR/ENTHDR transmit path.
// - Decodes START and Sr, then the address byte; ACKs the broadcast address 7'h7E/W by pulling SDA low.
// - Receives the CCC byte plus its T-bit. On ENTHDRx (0x20-0x27) it flags HDR entry to the target HDR engine.
// - Runs on the system clock by oversampling the synchronised SCL and SDA.
// PARAMETERS
// - SYNC_STAGES      2  : flops in each of the SCL and SDA input synchronisers (min 2).
// - ACK_RELEASE_DLY  2  : i_sdr_clk cycles after the ACK-bit SCL fall before SDA is released (min 1).
// - BCAST_ADDR       7'h7E : broadcast address that is ACKed.
// PORTS
// - i_sdr_clk        in   1  system clock; rising edge.
// - i_sdr_rst_n      in   1  asynchronous reset, active-low.
// - i_en             in   1  block enable; 0 forces IDLE and releases SDA.
// - i_scl            in   1  raw SCL from the pad.
// - i_sda            in   1  raw SDA from the pad (resolved bus value).
// - o_sda_pull_low   out  1  1 = open-drain pull SDA low (ACK); 0 = released.
// - o_start_det      out  1  1-cycle pulse on START or Sr.
// - o_stop_det       out  1  1-cycle pulse on STOP.
// - o_ccc_valid      out  1  1-cycle pulse; o_ccc_code is valid.
// - o_ccc_code       out  8  last received CCC byte; holds until the next o_ccc_valid.
// - o_parity_err     out  1  1-cycle pulse when the T-bit fails the odd-parity check.
// - o_hdr_active     out  1  level; set on accepted ENTHDRx, cleared on STOP or i_hdr_exit.
// - o_hdr_mode       out  3  ENTHDRx low 3 bits (0 = DDR); valid while o_hdr_active.
// - i_hdr_exit       in   1  pulse from the HDR engine when it detects the HDR exit pattern.
// BEHAVIOUR
// - Reset values: all outputs 0, FSM = IDLE, shift register = 0, bit counter = 0.
// - Synchronisers: s_scl/s_sda = SYNC_STAGES-flop copies, plus one history flop for edge detection.
// - Edge events: scl_rise, scl_fall, sda_fall, sda_rise.
// - Bus events:
//   - START = sda_fall while s_scl=1.
//   - STOP = sda_rise while s_scl=1.
// - Event latency: each pulse output asserts SYNC_STAGES+1 cycles after its pad edge.
// - Data sampling: SDA is sampled on scl_rise, MSB first. The bit counter increments on each scl_rise.
// - FSM states: IDLE, ADDR, ACK, CCC, HDR, IGNORE.
//   - IDLE: on START -> ADDR (counter cleared). All other edges ignored.
//   - ADDR: 8 bits {addr[6:0], RnW}.
//     - At the 8th scl_rise, if {addr,RnW} == {BCAST_ADDR,0} -> ACK.
//     - Otherwise -> IGNORE (NACK; SDA stays released).
//   - ACK:
//     - On the first scl_fall, o_sda_pull_low = 1 (next cycle).
//     - The 9th scl_rise is the ACK bit.
//     - On the following scl_fall, count ACK_RELEASE_DLY cycles, then o_sda_pull_low = 0 -> CCC.
//   - CCC: 9 bits {ccc[7:0], T}, sampled on scl_rise.
//     - At the 9th bit: o_ccc_code <= ccc and o_ccc_valid pulses.
//     - T check: T must equal ~^ccc (odd parity over 9 bits). Example: 0x20 -> T = 0.
//     - If ccc[7:3] == 5'b00100 and parity is OK: o_hdr_active = 1, o_hdr_mode = ccc[2:0] -> HDR.
//     - Otherwise -> IGNORE (CCC payload is not handled by this block).
//   - HDR: SDA/SCL edges ignored except STOP.
//     - STOP or i_hdr_exit -> clear o_hdr_active -> IDLE.
//     - START is not recognised in HDR.
//   - IGNORE: wait; START (Sr) -> ADDR, STOP -> IDLE.
// - START/STOP in any SDR state (ADDR, ACK, CCC) abort the frame.
//   - START -> ADDR; STOP -> IDLE.
//   - o_sda_pull_low drops in the same cycle the event is detected.
// - i_en = 0: synchronous abort to IDLE. o_sda_pull_low and o_hdr_active clear on the next cycle.
// - Async reset mid-ACK: o_sda_pull_low = 0 immediately (asynchronous).
// - Simultaneous STOP and i_hdr_exit in HDR: a single transition to IDLE; o_stop_det still pulses.
// - o_sda_pull_low is 1 only in ACK. It is never asserted while s_scl = 1 at the start of a bit.
// CONFIGURATION
// - I3C_TGT_RX_PARITY_CHK_EN defined:
//   - T-bit checked as above.
//   - On mismatch: o_parity_err pulses together with o_ccc_valid, the FSM -> IGNORE, and HDR is not entered.
// - Undefined:
//   - T-bit is sampled but ignored; o_parity_err is tied 0.
//   - ENTHDRx is accepted on code alone.
// TESTING
// - T1: START, 0xFC (7E/W) -> ACK.
//   - o_start_det pulses.
//   - o_sda_pull_low = 1 from the 8th scl_fall until 2 clocks after the 9th scl_fall.
// - T2: T1, then 9 bits 0x20, T = 0 -> o_ccc_valid pulses, o_ccc_code = 0x20, o_hdr_active = 1, o_hdr_mode = 0.
// - T3: START, 0xFE (7F/W) -> o_sda_pull_low stays 0 and the FSM goes to IGNORE.
//   - A following Sr with 0xFC is ACKed.
// - T4 (macro on): T1, then 0x20 with T = 1 -> o_parity_err pulses and o_hdr_active stays 0.
//   - With the macro off, the same stimulus gives o_hdr_active = 1.
// - T5: in HDR, 4 random SDA toggles while SCL is low -> no state change.
//   - Then STOP -> o_stop_det pulses and o_hdr_active = 0.
//   - Alternatively, i_hdr_exit -> IDLE.
// - T6: assert i_sdr_rst_n = 0 mid-ACK -> o_sda_pull_low = 0 immediately.
//   - After release, the next START with 0xFC is ACKed.

Source files
------------

// File: rtl/i3c_tgt_sdr_enthdr_rx_if.sv
// ============================================================================
// Module  : i3c_tgt_sdr_enthdr_rx_if
// Brief   : Pad-side bus and status bundle of the I3C target SDR/ENTHDR receiver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface i3c_tgt_sdr_enthdr_rx_if;
    logic       i_en;
    logic       i_scl;
    logic       i_sda;
    logic       i_hdr_exit;
    logic       o_sda_pull_low;
    logic       o_start_det;
    logic       o_stop_det;
    logic       o_ccc_valid;
    logic [7:0] o_ccc_code;
    logic       o_parity_err;
    logic       o_hdr_active;
    logic [2:0] o_hdr_mode;

    modport slave (
        input  i_en, i_scl, i_sda, i_hdr_exit,
        output o_sda_pull_low, o_start_det, o_stop_det, o_ccc_valid,
               o_ccc_code, o_parity_err, o_hdr_active, o_hdr_mode
    );

    modport master (
        output i_en, i_scl, i_sda, i_hdr_exit,
        input  o_sda_pull_low, o_start_det, o_stop_det, o_ccc_valid,
               o_ccc_code, o_parity_err, o_hdr_active, o_hdr_mode
    );
endinterface

`default_nettype wire

// File: rtl/i3c_tgt_sdr_enthdr_rx.sv
// ============================================================================
// Module  : i3c_tgt_sdr_enthdr_rx
// Brief   : Oversampling I3C target SDR front end: START/Sr/STOP decode, broadcast
//           address ACK, CCC capture and ENTHDRx detection. Optional T-bit parity
//           enforcement is enabled by defining I3C_TGT_RX_PARITY_CHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i3c_tgt_sdr_enthdr_rx #(
    parameter int         SYNC_STAGES     = 2,
    parameter int         ACK_RELEASE_DLY = 2,
    parameter logic [6:0] BCAST_ADDR      = 7'h7E
) (
    input  wire logic               i_sdr_clk,
    input  wire logic               i_sdr_rst_n,
    i3c_tgt_sdr_enthdr_rx_if.slave  bus
);

    localparam int c_rel_w = (ACK_RELEASE_DLY > 1) ? $clog2(ACK_RELEASE_DLY) : 1;
    localparam logic [c_rel_w-1:0] c_rel_load = c_rel_w'(ACK_RELEASE_DLY - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACK    = 3'd2,
        ST_CCC    = 3'd3,
        ST_HDR    = 3'd4,
        ST_IGNORE = 3'd5
    } state_e;

    // Synchronisers reset to the idle-bus level so reset release never fakes an edge.
    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_d, r_sda_d;

    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.i_sda};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    logic w_s_scl, w_s_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_s_scl    = r_scl_sync[SYNC_STAGES-1];
    assign w_s_sda    = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_s_scl & ~r_scl_d;
    assign w_scl_fall = ~w_s_scl & r_scl_d;
    assign w_start    = ~w_s_sda & r_sda_d & w_s_scl;
    assign w_stop     = w_s_sda & ~r_sda_d & w_s_scl;

    state_e               r_state, w_nxt_state;
    logic [3:0]           r_bit_cnt, w_nxt_bit_cnt;
    logic [7:0]           r_shift, w_nxt_shift;
    logic                 r_ack_bit, w_nxt_ack_bit;
    logic                 r_rel_busy, w_nxt_rel_busy;
    logic [c_rel_w-1:0]   r_rel_cnt, w_nxt_rel_cnt;
    logic                 r_pull, w_nxt_pull;
    logic                 r_start_det, w_nxt_start_det;
    logic                 r_stop_det, w_nxt_stop_det;
    logic                 r_ccc_valid, w_nxt_ccc_valid;
    logic [7:0]           r_ccc_code, w_nxt_ccc_code;
    logic                 r_parity_err, w_nxt_parity_err;
    logic                 r_hdr_active, w_nxt_hdr_active;
    logic [2:0]           r_hdr_mode, w_nxt_hdr_mode;

    logic [7:0] w_sh_in;
    logic       w_is_enthdr, w_perr, w_hdr_ok;
    assign w_sh_in     = {r_shift[6:0], w_s_sda};
    assign w_is_enthdr = (r_shift[7:3] == 5'b00100);

`ifdef I3C_TGT_RX_PARITY_CHK_EN
    // T must make the nine-bit {ccc, T} word odd parity.
    logic w_par_ok;
    assign w_par_ok = (w_s_sda == ~^r_shift);
    assign w_perr   = ~w_par_ok;
    assign w_hdr_ok = w_is_enthdr & w_par_ok;
`else
    assign w_perr   = 1'b0;
    assign w_hdr_ok = w_is_enthdr;
`endif

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_bit_cnt    = r_bit_cnt;
        w_nxt_shift      = r_shift;
        w_nxt_ack_bit    = r_ack_bit;
        w_nxt_rel_busy   = r_rel_busy;
        w_nxt_rel_cnt    = r_rel_cnt;
        w_nxt_pull       = r_pull;
        w_nxt_ccc_code   = r_ccc_code;
        w_nxt_hdr_active = r_hdr_active;
        w_nxt_hdr_mode   = r_hdr_mode;
        w_nxt_start_det  = w_start && (r_state != ST_HDR);
        w_nxt_stop_det   = w_stop;
        w_nxt_ccc_valid  = 1'b0;
        w_nxt_parity_err = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_nxt_state   = ST_ADDR;
                    w_nxt_bit_cnt = 4'd0;
                    w_nxt_shift   = 8'd0;
                end
            end

            ST_ADDR, ST_ACK, ST_CCC: begin
                if (w_stop || w_start) begin
                    w_nxt_state    = w_stop ? ST_IDLE : ST_ADDR;
                    w_nxt_bit_cnt  = 4'd0;
                    w_nxt_shift    = 8'd0;
                    w_nxt_pull     = 1'b0;
                    w_nxt_ack_bit  = 1'b0;
                    w_nxt_rel_busy = 1'b0;
                end else if (r_state == ST_ADDR) begin
                    if (w_scl_rise) begin
                        w_nxt_shift   = w_sh_in;
                        w_nxt_bit_cnt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_nxt_state   = (w_sh_in == {BCAST_ADDR, 1'b0}) ? ST_ACK : ST_IGNORE;
                            w_nxt_ack_bit = 1'b0;
                        end
                    end
                end else if (r_state == ST_ACK) begin
                    // First fall drives the ACK; the fall after the ACK bit arms the release delay.
                    if (r_rel_busy) begin
                        if (r_rel_cnt == '0) begin
                            w_nxt_pull     = 1'b0;
                            w_nxt_rel_busy = 1'b0;
                            w_nxt_ack_bit  = 1'b0;
                            w_nxt_state    = ST_CCC;
                            w_nxt_bit_cnt  = 4'd0;
                            w_nxt_shift    = 8'd0;
                        end else begin
                            w_nxt_rel_cnt = r_rel_cnt - c_rel_w'(1);
                        end
                    end else if (w_scl_rise) begin
                        w_nxt_ack_bit = 1'b1;
                        w_nxt_bit_cnt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (!r_ack_bit) begin
                            w_nxt_pull = 1'b1;
                        end else begin
                            w_nxt_rel_busy = 1'b1;
                            w_nxt_rel_cnt  = c_rel_load;
                        end
                    end
                end else begin
                    if (w_scl_rise) begin
                        w_nxt_shift   = w_sh_in;
                        w_nxt_bit_cnt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd8) begin
                            w_nxt_ccc_code   = r_shift;
                            w_nxt_ccc_valid  = 1'b1;
                            w_nxt_parity_err = w_perr;
                            if (w_hdr_ok) begin
                                w_nxt_hdr_active = 1'b1;
                                w_nxt_hdr_mode   = r_shift[2:0];
                                w_nxt_state      = ST_HDR;
                            end else begin
                                w_nxt_state = ST_IGNORE;
                            end
                        end
                    end
                end
            end

            ST_HDR: begin
                if (w_stop || bus.i_hdr_exit) begin
                    w_nxt_hdr_active = 1'b0;
                    w_nxt_state      = ST_IDLE;
                end
            end

            ST_IGNORE: begin
                if (w_stop) begin
                    w_nxt_state = ST_IDLE;
                end else if (w_start) begin
                    w_nxt_state   = ST_ADDR;
                    w_nxt_bit_cnt = 4'd0;
                    w_nxt_shift   = 8'd0;
                end
            end

            default: w_nxt_state = ST_IDLE;
        endcase

        if (!bus.i_en) begin
            w_nxt_state      = ST_IDLE;
            w_nxt_pull       = 1'b0;
            w_nxt_hdr_active = 1'b0;
            w_nxt_ack_bit    = 1'b0;
            w_nxt_rel_busy   = 1'b0;
            w_nxt_start_det  = 1'b0;
            w_nxt_stop_det   = 1'b0;
            w_nxt_ccc_valid  = 1'b0;
            w_nxt_parity_err = 1'b0;
            w_nxt_ccc_code   = r_ccc_code;
        end
    end

    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'd0;
            r_ack_bit    <= 1'b0;
            r_rel_busy   <= 1'b0;
            r_rel_cnt    <= '0;
            r_pull       <= 1'b0;
            r_start_det  <= 1'b0;
            r_stop_det   <= 1'b0;
            r_ccc_valid  <= 1'b0;
            r_ccc_code   <= 8'd0;
            r_parity_err <= 1'b0;
            r_hdr_active <= 1'b0;
            r_hdr_mode   <= 3'd0;
        end else begin
            r_state      <= w_nxt_state;
            r_bit_cnt    <= w_nxt_bit_cnt;
            r_shift      <= w_nxt_shift;
            r_ack_bit    <= w_nxt_ack_bit;
            r_rel_busy   <= w_nxt_rel_busy;
            r_rel_cnt    <= w_nxt_rel_cnt;
            r_pull       <= w_nxt_pull;
            r_start_det  <= w_nxt_start_det;
            r_stop_det   <= w_nxt_stop_det;
            r_ccc_valid  <= w_nxt_ccc_valid;
            r_ccc_code   <= w_nxt_ccc_code;
            r_parity_err <= w_nxt_parity_err;
            r_hdr_active <= w_nxt_hdr_active;
            r_hdr_mode   <= w_nxt_hdr_mode;
        end
    end

    assign bus.o_sda_pull_low = r_pull;
    assign bus.o_start_det    = r_start_det;
    assign bus.o_stop_det     = r_stop_det;
    assign bus.o_ccc_valid    = r_ccc_valid;
    assign bus.o_ccc_code     = r_ccc_code;
    assign bus.o_parity_err   = r_parity_err;
    assign bus.o_hdr_active   = r_hdr_active;
    assign bus.o_hdr_mode     = r_hdr_mode;

endmodule

`default_nettype wire

// File: tb/tb_i3c_tgt_sdr_enthdr_rx.sv
// ============================================================================
// Module  : tb_i3c_tgt_sdr_enthdr_rx
// Brief   : Randomised frame-level bench for the I3C target SDR/ENTHDR receiver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i3c_tgt_sdr_enthdr_rx;

    localparam int c_sync = 2;
    localparam int c_dly  = 2;
`ifdef I3C_TGT_RX_PARITY_CHK_EN
    localparam bit c_par_chk = 1'b1;
`else
    localparam bit c_par_chk = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sda_drv;

    i3c_tgt_sdr_enthdr_rx_if bus ();

    // Open-drain bus: the resolved SDA is low if either side pulls it low.
    assign bus.i_sda = sda_drv & ~bus.o_sda_pull_low;

    i3c_tgt_sdr_enthdr_rx #(
        .SYNC_STAGES     (c_sync),
        .ACK_RELEASE_DLY (c_dly),
        .BCAST_ADDR      (7'h7E)
    ) u_dut (
        .i_sdr_clk   (clk),
        .i_sdr_rst_n (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_start = 0, n_stop = 0, n_valid = 0, n_perr = 0;

    always @(negedge clk) begin
        if (bus.o_start_det)  n_start++;
        if (bus.o_stop_det)   n_stop++;
        if (bus.o_ccc_valid)  n_valid++;
        if (bus.o_parity_err) n_perr++;
    end

    logic [7:0] m_code;
    bit         m_hdr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input int post);
        sda_drv = b;
        repeat (5) tick();
        bus.i_scl = 1'b1;
        repeat (10) tick();
        bus.i_scl = 1'b0;
        repeat (post) tick();
    endtask

    task automatic do_start();
        if (!bus.i_scl) begin
            sda_drv = 1'b1;
            repeat (5) tick();
            bus.i_scl = 1'b1;
            repeat (5) tick();
        end
        sda_drv = 1'b0;
        repeat (c_sync) tick();
        check("start_early", bus.o_start_det, 0);
        tick();
        check("start_det", bus.o_start_det, 1);
        tick();
        check("start_width", bus.o_start_det, 0);
        repeat (3) tick();
        bus.i_scl = 1'b0;
        repeat (5) tick();
    endtask

    task automatic do_stop();
        sda_drv = 1'b0;
        repeat (5) tick();
        bus.i_scl = 1'b1;
        repeat (5) tick();
        sda_drv = 1'b1;
        repeat (c_sync) tick();
        check("stop_early", bus.o_stop_det, 0);
        tick();
        check("stop_det", bus.o_stop_det, 1);
        check("stop_hdr_clr", bus.o_hdr_active, 0);
        m_hdr = 1'b0;
        repeat (5) tick();
    endtask

    task automatic send_addr(input logic [7:0] addr);
        for (int i = 7; i >= 1; i--) send_bit(addr[i], 5);
        send_bit(addr[0], 0);
    endtask

    task automatic run_frame(input logic [7:0] addr, input logic [7:0] ccc, input bit t);
        bit exp_ack, par_ok, exp_hdr, exp_perr;
        int v0, p0;
        exp_ack  = (addr == 8'hFC);
        par_ok   = ($countones({ccc, t}) % 2) == 1;
        exp_hdr  = exp_ack && (ccc >= 8'h20) && (ccc <= 8'h27) && (par_ok || !c_par_chk);
        exp_perr = exp_ack && c_par_chk && !par_ok;

        send_addr(addr);
        repeat (c_sync) tick();
        check("pull_early", bus.o_sda_pull_low, 0);
        tick();
        check("pull_on", bus.o_sda_pull_low, exp_ack);
        sda_drv = 1'b1;
        repeat (2) tick();
        bus.i_scl = 1'b1;
        repeat (10) tick();
        check("ack_sda", bus.i_sda, !exp_ack);
        bus.i_scl = 1'b0;
        repeat (c_sync + c_dly) tick();
        check("pull_hold", bus.o_sda_pull_low, exp_ack);
        tick();
        check("pull_off", bus.o_sda_pull_low, 0);
        repeat (2) tick();

        v0 = n_valid;
        p0 = n_perr;
        for (int i = 7; i >= 0; i--) send_bit(ccc[i], 5);
        send_bit(t, 5);
        if (exp_ack) m_code = ccc;
        check("ccc_valid_cnt", n_valid - v0, exp_ack);
        check("ccc_code", bus.o_ccc_code, m_code);
        check("parity_err_cnt", n_perr - p0, exp_perr);
        check("hdr_active", bus.o_hdr_active, exp_hdr);
        if (exp_hdr) check("hdr_mode", bus.o_hdr_mode, ccc % 8);
        m_hdr = exp_hdr;
    endtask

    // how: 0 = STOP, 1 = i_hdr_exit then STOP, 2 = i_en drop then STOP
    task automatic leave_hdr(input int how);
        int s0, t0;
        s0 = n_start;
        t0 = n_stop;
        for (int k = 0; k < 4; k++) begin
            sda_drv = ~sda_drv;
            repeat ($urandom_range(2, 6)) tick();
        end
        repeat (4) tick();
        check("hdr_toggle_keep", bus.o_hdr_active, 1);
        check("hdr_toggle_evts", (n_start - s0) + (n_stop - t0), 0);
        check("hdr_pull", bus.o_sda_pull_low, 0);
        if (how == 1) begin
            bus.i_hdr_exit = 1'b1;
            tick();
            bus.i_hdr_exit = 1'b0;
            check("hdr_exit_clr", bus.o_hdr_active, 0);
            m_hdr = 1'b0;
        end else if (how == 2) begin
            bus.i_en = 1'b0;
            tick();
            check("en_off_clr", bus.o_hdr_active, 0);
            bus.i_en = 1'b1;
            m_hdr = 1'b0;
            tick();
        end
        do_stop();
    endtask

    function automatic bit good_t(input logic [7:0] c);
        return ($countones(c) % 2) == 0;
    endfunction

    initial begin
        logic [7:0] a, c;
        bit         t;
        bus.i_scl      = 1'b1;
        bus.i_en       = 1'b1;
        bus.i_hdr_exit = 1'b0;
        sda_drv        = 1'b1;
        m_code         = 8'h00;
        m_hdr          = 1'b0;

        repeat (3) tick();
        check("rst_pull", bus.o_sda_pull_low, 0);
        check("rst_start", bus.o_start_det, 0);
        check("rst_stop", bus.o_stop_det, 0);
        check("rst_valid", bus.o_ccc_valid, 0);
        check("rst_code", bus.o_ccc_code, 0);
        check("rst_perr", bus.o_parity_err, 0);
        check("rst_hdr", bus.o_hdr_active, 0);
        check("rst_mode", bus.o_hdr_mode, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // broadcast ACK then ENTHDR0, leave with STOP
        do_start();
        run_frame(8'hFC, 8'h20, 1'b0);
        leave_hdr(0);

        // NACK on 7F/W, then Sr to broadcast and ENTHDR1, leave via i_hdr_exit
        do_start();
        run_frame(8'hFE, 8'h20, 1'b0);
        do_start();
        run_frame(8'hFC, 8'h21, good_t(8'h21));
        leave_hdr(1);

        // ENTHDR0 with wrong T-bit
        do_start();
        run_frame(8'hFC, 8'h20, 1'b1);
        if (m_hdr) leave_hdr(2);
        else do_stop();

        // asynchronous reset while the ACK is driven
        do_start();
        send_addr(8'hFC);
        repeat (c_sync + 1) tick();
        check("pre_rst_pull", bus.o_sda_pull_low, 1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_pull", bus.o_sda_pull_low, 0);
        sda_drv = 1'b1;
        m_code  = 8'h00;
        m_hdr   = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        do_start();
        run_frame(8'hFC, 8'h22, good_t(8'h22));
        leave_hdr(0);

        for (int n = 0; n < 20; n++) begin
            do_start();
            a = ($urandom_range(0, 1) == 1) ? 8'hFC : 8'($urandom);
            c = ($urandom_range(0, 1) == 1) ? 8'h20 + 8'($urandom_range(0, 7)) : 8'($urandom);
            t = ($urandom_range(0, 3) == 0) ? ~good_t(c) : good_t(c);
            run_frame(a, c, t);
            if (m_hdr) leave_hdr($urandom_range(0, 2));
            else if ($urandom_range(0, 1) == 1) do_stop();
        end
        if (!bus.i_scl) do_stop();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
